digdug_vram_arb: RTL

DIGDUG_VRAM_ARB -- requirements
Module: digdug_vram_arb

---
 rtl/digdug_vram_arb.sv | 53 +++++
 1 files changed

// File: rtl/digdug_vram_arb.sv
// digdug_vram_arb: 8-slot arbiter sharing one synchronous VRAM between the video scan and the CPU.
// Slots 0-1 belong to video; the CPU may start one access in any of slots 2-7.
module digdug_vram_arb (
  input  logic       CLK48M,
  input  logic       RESET,
  input  logic [9:0] VAD,
  output logic [7:0] VDT,
  output logic       VSTB,
  input  logic       CREQ,
  input  logic       CWE,
  input  logic [9:0] CAD,
  input  logic [7:0] CWD,
  output logic [7:0] CRD,
  output logic       CACK,
  output logic [9:0] RAM_AD,
  output logic       RAM_WE,
  output logic [7:0] RAM_WD,
  input  logic [7:0] RAM_DT,
  output logic [2:0] SLOT
);
  typedef enum logic [1:0] {IDLE, RDAT, ACK, HOLD} state_t;
  state_t state;
  logic acc;
  assign acc = state == IDLE && CREQ && SLOT >= 3'd2;
  assign RAM_AD = acc ? CAD : VAD;
  assign RAM_WE = acc && CWE;
  assign RAM_WD = acc ? CWD : 8'h00;
  // Video fetch: address in slot 0, data arrives in slot 1 and is latched at its end.
  always_ff @(posedge CLK48M or posedge RESET)
    if (RESET) begin
      SLOT <= 3'd0;
      VDT <= 8'h00;
      VSTB <= 1'b0;
    end else begin
      SLOT <= SLOT + 3'd1;
      VSTB <= SLOT == 3'd1;
      if (SLOT == 3'd1) VDT <= RAM_DT;
    end
  // HOLD waits for CREQ to drop so a level request yields a single access.
  always_ff @(posedge CLK48M or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      CRD <= 8'h00;
      CACK <= 1'b0;
    end else begin
      CACK <= (acc && CWE) || state == RDAT;
      if (state == RDAT) CRD <= RAM_DT;
      state <= acc ? (CWE ? ACK : RDAT) :
               state == RDAT ? ACK :
               state == ACK ? HOLD :
               (state == HOLD && !CREQ) ? IDLE : state;
    end
endmodule
